uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer directly downstream of the UART receiver.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_fifo_mem.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and byte type, used by the receiver and its FIFO.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage with one write port and one registered read port.
// The read port is write-first: a write to the address being read lands
// directly in the read register, which gives the FIFO its empty-case fill path.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [UART_BYTE_W-1:0] wr_data_i,
    input  logic [AW-1:0]          rd_addr_i,
    output logic [UART_BYTE_W-1:0] rd_data_o
);

    uart_byte_t mem_q [DEPTH];
    uart_byte_t rd_data_q;
    uart_byte_t rd_data_d;

    // Storage array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read mux with write-first forwarding on an address collision.
    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
        if (we_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver, first-word fall-through,
// with sticky overflow flag. Optional RTS flow control when UART_RX_FIFO_RTS_EN
// is defined (adds rts_n port and RTS_MARGIN parameter).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4
`ifdef UART_RX_FIFO_RTS_EN
    ,
    parameter int unsigned RTS_MARGIN = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [UART_BYTE_W-1:0] in_data,
    input  logic                   in_valid,
    output logic [UART_BYTE_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW:0]            count,
    output logic                   overflow,
    input  logic                   ovf_clr
`ifdef UART_RX_FIFO_RTS_EN
    ,
    output logic                   rts_n
`endif
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        out_valid_q, out_valid_d;
    logic        overflow_q, overflow_d;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;

    // Handshake decode, pointer/count/flag next-state.
    always_comb begin
        full        = (count_q == (AW+1)'(DEPTH));
        pop         = out_valid_q & out_ready;
        push        = in_valid & (~full | pop);
        drop        = in_valid & full & ~pop;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q & ~ovf_clr) | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        out_valid_d = (count_d != '0);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage; reading at the next read pointer keeps out_data aligned with the head.
    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rstn),
        .we_i      (push),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_d[AW-1:0]),
        .rd_data_o (out_data)
    );

    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_RTS_EN
    logic rts_n_q, rts_n_d;

    // Ask the sender to stop once free space drops to the margin.
    always_comb begin
        rts_n_d = (count_d >= (AW+1)'(DEPTH - RTS_MARGIN));
    end

    // RTS register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rts_n_q <= 1'b0;
        end else begin
            rts_n_q <= rts_n_d;
        end
    end

    assign rts_n = rts_n_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (RTS checks when UART_RX_FIFO_RTS_EN is defined).
module tb_uart_rx_fifo;

    logic       clk;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
`ifdef UART_RX_FIFO_RTS_EN
    logic       rts_n;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
`ifdef UART_RX_FIFO_RTS_EN
        ,
        .rts_n     (rts_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_b;
        rstn      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
`ifdef UART_RX_FIFO_RTS_EN
        check("rst_rts", 32'(rts_n), 32'd0);
`endif
        tick();
        rstn = 1'b1;
        tick();

        // single byte in, single byte out
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_pop_count", 32'(count), 32'd0);
        check("t1_pop_valid", 32'(out_valid), 32'd0);

        // push and pop together with one entry: new byte becomes head
        in_data = 8'hAA; in_valid = 1'b1;
        tick();
        in_data = 8'hBB; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp1_count", 32'(count), 32'd1);
        check("pp1_data", 32'(out_data), 32'hBB);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp1_empty", 32'(count), 32'd0);

        // fill to 16 with 00..0F, pointers start mid-array so writes wrap
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t2_count", 32'(count), 32'd16);
        check("t2_head", 32'(out_data), 32'h00);

        // overflow on full without pop
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_count", 32'(count), 32'd16);
        check("t3_head", 32'(out_data), 32'h00);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_clr", 32'(overflow), 32'd0);

        // clear and new drop in the same cycle: set wins
        in_data = 8'hFF; in_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_setwins", 32'(overflow), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("t3_clr2", 32'(overflow), 32'd0);

        // full, push with pop in the same cycle
        in_data = 8'h55; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("t4_count", 32'(count), 32'd16);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_head", 32'(out_data), 32'h01);
        tick();
        check("t4_stable", 32'(out_data), 32'h01);

        // drain: 01..0F then 55
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(i + 1) : 8'h55;
            check("t4_drain", 32'(out_data), 32'(exp_b));
            tick();
        end
        out_ready = 1'b0;
        check("t4_empty_count", 32'(count), 32'd0);
        check("t4_empty_valid", 32'(out_valid), 32'd0);

        // out_ready while empty is ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_ready", 32'(count), 32'd0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) begin
            in_data = 8'(8'h30 + i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t5_count7", 32'(count), 32'd7);
        #2;
        rstn = 1'b0;
        #1;
        check("t5_async_count", 32'(count), 32'd0);
        check("t5_async_valid", 32'(out_valid), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("t5_after", 32'(count), 32'd0);

`ifdef UART_RX_FIFO_RTS_EN
        // RTS threshold at DEPTH-MARGIN = 12
        for (int i = 0; i < 11; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t6_count11", 32'(count), 32'd11);
        check("t6_rts11", 32'(rts_n), 32'd0);
        in_data = 8'h0B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t6_rts12", 32'(rts_n), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_count_back", 32'(count), 32'd11);
        check("t6_rts_fall", 32'(rts_n), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
